// File: rtl/vga_line_fetch_arb.sv
// vga_line_fetch_arb: fills the ping-pong VGA line buffers (A/B) from the frame buffer in
// external memory. It shares the single memory read port between the line fetcher
// (high priority, deadline-bound) and one auxiliary single-word requester.
// Optional build macro: FETCH_STATS_EN adds the underrun_cnt and aux_wait_max outputs.
module vga_line_fetch_arb #(
    parameter logic [23:0] FB_BASE   = 24'h000000,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned AUX_SLOTS = 1
) (
    input  logic        vga_clk,
    input  logic        rst_n_w,
    input  logic        vga_mode,
    input  logic        blanking,
    input  logic        read_buff_req,
    input  logic        read_buff_A_B,
    input  logic [9:0]  read_buff_addr,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic [10:0] mem_len,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        buf_wr_en,
    output logic        buf_wr_sel,
    output logic [9:0]  buf_wr_addr,
    output logic [15:0] buf_wr_data,
    input  logic        aux_req,
    input  logic [23:0] aux_addr,
    output logic        aux_ack,
    output logic        aux_rvalid,
    output logic [15:0] aux_rdata,
    output logic        underrun
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] underrun_cnt,
    output logic [15:0] aux_wait_max
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLReq,
        StLData,
        StAReq,
        StAData
    } state_e;

    state_e      state_q;
    logic        req_q;        // read_buff_req delayed one cycle, for edge detect
    logic        line_pend_q;
    logic        sel_q;
    logic [10:0] words_q;
    logic [23:0] line_base_q;
    logic [10:0] pix_q;
    logic [10:0] beat_q;
    logic [7:0]  slots_q;
    logic        drain_q;      // discard the rest of a burst that belongs to an abandoned line
    logic        underrun_q;

    logic        start;
    logic        restart;
    logic        last_beat;
    logic        slot_free;
    logic [23:0] line_off;

    // Blanking is informational only: with no line pending aux is served regardless.
    logic unused_blanking;
    assign unused_blanking = blanking;

    assign start     = read_buff_req & ~req_q;
    // A new line request before the previous one finished is a missed deadline.
    assign restart   = start & line_pend_q;
    assign last_beat = mem_rvalid & (beat_q == 11'(BURST_LEN - 1));
    assign slot_free = aux_req & ({24'b0, slots_q} < AUX_SLOTS);
    assign underrun  = underrun_q;

    // Line offset in words: line*1024 or line*640 built from shifts.
    always_comb begin
        if (vga_mode) begin
            line_off = {4'b0, read_buff_addr, 10'b0};
        end else begin
            line_off = {5'b0, read_buff_addr, 9'b0} + {7'b0, read_buff_addr, 7'b0};
        end
    end

    // Arbitration FSM plus the line/burst bookkeeping it owns.
    always_ff @(posedge vga_clk or negedge rst_n_w) begin
        if (!rst_n_w) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            line_pend_q <= 1'b0;
            sel_q       <= 1'b0;
            words_q     <= 11'd0;
            line_base_q <= 24'd0;
            pix_q       <= 11'd0;
            beat_q      <= 11'd0;
            slots_q     <= 8'd0;
            drain_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            req_q <= read_buff_req;
            if (restart) begin
                underrun_q <= 1'b1;
            end
            if (start) begin
                sel_q       <= read_buff_A_B;
                words_q     <= vga_mode ? 11'd1024 : 11'd640;
                line_base_q <= FB_BASE + line_off;
                pix_q       <= 11'd0;
                line_pend_q <= 1'b1;
                slots_q     <= 8'd0;
            end
            unique case (state_q)
                StIdle: begin
                    if (line_pend_q || start) begin
                        state_q <= StLReq;
                    end else if (aux_req) begin
                        state_q <= StAReq;
                    end
                end
                StLReq: begin
                    if (mem_ack) begin
                        beat_q  <= 11'd0;
                        slots_q <= 8'd0;
                        state_q <= StLData;
                        // The accepted burst still addresses the old line.
                        if (restart) begin
                            drain_q <= 1'b1;
                        end
                    end
                end
                StLData: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 11'd1;
                        if (!drain_q && !restart) begin
                            pix_q <= pix_q + 11'd1;
                        end
                    end
                    if (last_beat) begin
                        drain_q <= 1'b0;
                        if (restart || drain_q) begin
                            state_q <= StLReq;
                        end else if (pix_q + 11'd1 == words_q) begin
                            line_pend_q <= 1'b0;
                            state_q     <= StIdle;
                        end else if (slot_free) begin
                            slots_q <= slots_q + 8'd1;
                            state_q <= StAReq;
                        end else begin
                            state_q <= StLReq;
                        end
                    end else if (restart) begin
                        drain_q <= 1'b1;
                    end
                end
                StAReq: begin
                    if (mem_ack) begin
                        state_q <= StAData;
                    end
                end
                StAData: begin
                    if (mem_rvalid) begin
                        if (line_pend_q || start) begin
                            if (!start && slot_free) begin
                                slots_q <= slots_q + 8'd1;
                                state_q <= StAReq;
                            end else begin
                                state_q <= StLReq;
                            end
                        end else if (aux_req) begin
                            state_q <= StAReq;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory request and buffer/aux strobes decoded from the registered state.
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = 24'd0;
        mem_len     = 11'd0;
        buf_wr_en   = 1'b0;
        buf_wr_sel  = 1'b0;
        buf_wr_addr = 10'd0;
        buf_wr_data = 16'd0;
        aux_ack     = 1'b0;
        aux_rvalid  = 1'b0;
        aux_rdata   = 16'd0;
        case (state_q)
            StLReq: begin
                mem_req  = 1'b1;
                mem_addr = line_base_q + {13'b0, pix_q};
                mem_len  = 11'(BURST_LEN);
            end
            StLData: begin
                if (mem_rvalid && !drain_q && !restart) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_sel  = sel_q;
                    buf_wr_addr = pix_q[9:0];
                    buf_wr_data = mem_rdata;
                end
            end
            StAReq: begin
                mem_req  = 1'b1;
                mem_addr = aux_addr;
                mem_len  = 11'd1;
                aux_ack  = mem_ack;
            end
            StAData: begin
                if (mem_rvalid) begin
                    aux_rvalid = 1'b1;
                    aux_rdata  = mem_rdata;
                end
            end
            default: ;
        endcase
    end

`ifdef FETCH_STATS_EN
    logic        aux_req_q;
    logic        aux_armed_q;
    logic [15:0] aux_wait_cnt_q;
    logic [15:0] underrun_cnt_q;
    logic [15:0] aux_wait_max_q;
    logic        aux_rise;
    logic [15:0] aux_wait_now;

    assign aux_rise     = aux_req & ~aux_req_q;
    assign aux_wait_now = aux_rise ? 16'd0 : aux_wait_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
    assign aux_wait_max = aux_wait_max_q;

    // Saturating underrun counter and worst-case aux request-to-issue latency.
    always_ff @(posedge vga_clk or negedge rst_n_w) begin
        if (!rst_n_w) begin
            aux_req_q      <= 1'b0;
            aux_armed_q    <= 1'b0;
            aux_wait_cnt_q <= 16'd0;
            underrun_cnt_q <= 16'd0;
            aux_wait_max_q <= 16'd0;
        end else begin
            aux_req_q <= aux_req;
            if (restart && (underrun_cnt_q != 16'hFFFF)) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
            if (aux_ack && (aux_rise || aux_armed_q)) begin
                aux_armed_q <= 1'b0;
                if (aux_wait_now > aux_wait_max_q) begin
                    aux_wait_max_q <= aux_wait_now;
                end
            end else if (aux_rise) begin
                aux_armed_q    <= 1'b1;
                aux_wait_cnt_q <= 16'd1;
            end else if (aux_armed_q && (aux_wait_cnt_q != 16'hFFFF)) begin
                aux_wait_cnt_q <= aux_wait_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_line_fetch_arb.sv
// Self-checking bench for vga_line_fetch_arb: a randomized memory responder plus queue-based
// logs of memory transactions, buffer writes and aux returns, checked against line
// contents and burst sequences computed directly from line number, mode and base address.
module tb_vga_line_fetch_arb;

    localparam int AUX_SLOTS = 1;

    logic        vga_clk        = 1'b0;
    logic        rst_n_w        = 1'b0;
    logic        vga_mode       = 1'b0;
    logic        blanking       = 1'b0;
    logic        read_buff_req  = 1'b0;
    logic        read_buff_A_B  = 1'b0;
    logic [9:0]  read_buff_addr = 10'd0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [10:0] mem_len;
    logic        mem_ack        = 1'b0;
    logic        mem_rvalid     = 1'b0;
    logic [15:0] mem_rdata      = 16'd0;
    logic        buf_wr_en;
    logic        buf_wr_sel;
    logic [9:0]  buf_wr_addr;
    logic [15:0] buf_wr_data;
    logic        aux_req        = 1'b0;
    logic [23:0] aux_addr       = 24'd0;
    logic        aux_ack;
    logic        aux_rvalid;
    logic [15:0] aux_rdata;
    logic        underrun;

    vga_line_fetch_arb dut (
        .vga_clk        (vga_clk),
        .rst_n_w        (rst_n_w),
        .vga_mode       (vga_mode),
        .blanking       (blanking),
        .read_buff_req  (read_buff_req),
        .read_buff_A_B  (read_buff_A_B),
        .read_buff_addr (read_buff_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_len        (mem_len),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_sel     (buf_wr_sel),
        .buf_wr_addr    (buf_wr_addr),
        .buf_wr_data    (buf_wr_data),
        .aux_req        (aux_req),
        .aux_addr       (aux_addr),
        .aux_ack        (aux_ack),
        .aux_rvalid     (aux_rvalid),
        .aux_rdata      (aux_rdata),
        .underrun       (underrun)
    );

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Logs filled by the monitor.
    logic [23:0] tq_addr[$];
    logic [10:0] tq_len[$];
    logic        wq_sel[$];
    logic [9:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    logic [15:0] aux_dq[$];
    int          n_aux_ack = 0;
    bit          chk_b2b = 1'b0;
    logic        last_aux_rv = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory content: a fixed scramble of the word address.
    function automatic logic [15:0] mdata(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
    endfunction

    // One memory transaction: random accept delay, then len words with random gaps.
    task automatic mem_serve();
        logic [23:0] a;
        int          l;
        repeat ($urandom_range(0, 3)) begin
            @(negedge vga_clk);
            if (!rst_n_w) return;
        end
        a = mem_addr;
        l = int'(mem_len);
        mem_ack = 1'b1;
        @(negedge vga_clk);
        mem_ack = 1'b0;
        if (!rst_n_w) return;
        for (int i = 0; i < l; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge vga_clk);
                if (!rst_n_w) return;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mdata(a + 24'(i));
            @(negedge vga_clk);
            mem_rvalid = 1'b0;
            if (!rst_n_w) return;
        end
    endtask

    initial begin
        forever begin
            @(negedge vga_clk);
            if (rst_n_w && mem_req) mem_serve();
        end
    end

    // Monitor: samples settled outputs 2 time units after the driving edge.
    always @(negedge vga_clk) begin
        #2;
        if (rst_n_w) begin
            if (mem_req && mem_ack) begin
                tq_addr.push_back(mem_addr);
                tq_len.push_back(mem_len);
            end
            if (buf_wr_en) begin
                wq_sel.push_back(buf_wr_sel);
                wq_addr.push_back(buf_wr_addr);
                wq_data.push_back(buf_wr_data);
            end
            if (aux_ack) n_aux_ack++;
            if (aux_rvalid) aux_dq.push_back(aux_rdata);
            if (chk_b2b && last_aux_rv) begin
                check_eq("b2b_req", 64'({mem_req, mem_addr}), 64'({1'b1, aux_addr}));
            end
            last_aux_rv = aux_rvalid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        tq_addr.delete();
        tq_len.delete();
        wq_sel.delete();
        wq_addr.delete();
        wq_data.delete();
        aux_dq.delete();
        n_aux_ack = 0;
    endtask

    // Caller is at a negedge; produces one rising edge on read_buff_req.
    task automatic start_line(input logic [9:0] line, input logic ab, input logic mode);
        read_buff_addr = line;
        read_buff_A_B  = ab;
        vga_mode       = mode;
        read_buff_req  = 1'b1;
        @(negedge vga_clk);
        read_buff_req  = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input bit toggle);
        int k;
        k = 0;
        while (wq_sel.size() < n && k < budget) begin
            @(negedge vga_clk);
            k++;
            if (toggle && $urandom_range(0, 3) == 0) aux_req = ~aux_req;
        end
        check_eq("wait_writes", 64'(wq_sel.size() >= n), 64'd1);
    endtask

    task automatic settle();
        aux_req = 1'b0;
        repeat (40) @(negedge vga_clk);
        check_eq("idle_req", 64'(mem_req), 64'd0);
    endtask

    task automatic check_line(input string tag, input int first, input int n, input logic sel,
                              input logic [23:0] base);
        int bad;
        bad = 0;
        for (int p = 0; p < n; p++) begin
            if (first + p >= wq_sel.size()) bad++;
            else if (wq_sel[first+p] !== sel || wq_addr[first+p] !== 10'(p) ||
                     wq_data[first+p] !== mdata(base + 24'(p))) bad++;
        end
        check_eq({tag, "_wr_bad"}, 64'(bad), 64'd0);
    endtask

    task automatic check_bursts(input string tag, input int b0, input int nb,
                                input logic [23:0] base, input int total);
        int k;
        int bad;
        k = 0;
        bad = 0;
        foreach (tq_len[i]) begin
            if (tq_len[i] != 11'd1) begin
                if (k >= b0 && k < b0 + nb) begin
                    if (tq_addr[i] !== base + 24'(64 * (k - b0)) || tq_len[i] !== 11'd64) bad++;
                end
                k++;
            end
        end
        check_eq({tag, "_nburst"}, 64'(k), 64'(total));
        check_eq({tag, "_burst_bad"}, 64'(bad), 64'd0);
    endtask

    task automatic check_aux(input string tag, input bit exact, input logic [23:0] addr);
        int gap;
        int bad_gap;
        int bad_addr;
        int bad_data;
        bit seen;
        gap = 0;
        bad_gap = 0;
        bad_addr = 0;
        bad_data = 0;
        seen = 1'b0;
        foreach (tq_len[i]) begin
            if (tq_len[i] == 11'd1) begin
                gap++;
                if (tq_addr[i] !== addr) bad_addr++;
            end else begin
                if (seen && (exact ? (gap != 1) : (gap > AUX_SLOTS))) bad_gap++;
                seen = 1'b1;
                gap = 0;
            end
        end
        foreach (aux_dq[i]) if (aux_dq[i] !== mdata(addr)) bad_data++;
        check_eq({tag, "_aux_gap"}, 64'(bad_gap), 64'd0);
        check_eq({tag, "_aux_addr"}, 64'(bad_addr), 64'd0);
        check_eq({tag, "_aux_data"}, 64'(bad_data), 64'd0);
        check_eq({tag, "_aux_cnt"}, 64'(n_aux_ack), 64'(aux_dq.size()));
    endtask

    initial begin
        logic [9:0]  ln;
        logic        ab;
        logic        md;
        logic [23:0] base;
        logic [23:0] aa;
        int          words;
        int          k;

        #1;
        check_eq("rst_out_a", 64'({mem_req, mem_addr, mem_len, buf_wr_en, buf_wr_sel,
                                   buf_wr_addr}), 64'd0);
        check_eq("rst_out_b", 64'({buf_wr_data, aux_ack, aux_rvalid, aux_rdata, underrun}),
                 64'd0);
        repeat (3) @(negedge vga_clk);
        rst_n_w = 1'b1;
        repeat (2) @(negedge vga_clk);

        // 640-word line 5 into buffer B.
        start_line(10'd5, 1'b1, 1'b0);
        wait_writes(640, 6000, 1'b0);
        settle();
        check_eq("t1_nwr", 64'(wq_sel.size()), 64'd640);
        check_line("t1", 0, 640, 1'b1, 24'd3200);
        check_bursts("t1", 0, 10, 24'd3200, 10);
        check_eq("t1_underrun", 64'(underrun), 64'd0);
        clear_logs();

        // 1024-word line 767 into buffer A.
        start_line(10'd767, 1'b0, 1'b1);
        wait_writes(1024, 8000, 1'b0);
        settle();
        check_eq("t2_nwr", 64'(wq_sel.size()), 64'd1024);
        check_line("t2", 0, 1024, 1'b0, 24'd785408);
        check_bursts("t2", 0, 16, 24'd785408, 16);
        if (wq_addr.size() > 0) check_eq("t2_last_addr", 64'(wq_addr[wq_addr.size()-1]), 64'd1023);
        else check_eq("t2_last_addr", 64'd0, 64'd1023);
        clear_logs();

        // Aux held for the whole line: exactly one aux transaction per burst gap.
        ln = 10'($urandom_range(0, 1023));
        start_line(ln, 1'b0, 1'b0);
        aux_addr = 24'h123456;
        aux_req  = 1'b1;
        wait_writes(640, 8000, 1'b0);
        settle();
        base = 24'(int'(ln) * 640);
        check_line("t3", 0, 640, 1'b0, base);
        check_bursts("t3", 0, 10, base, 10);
        check_aux("t3", 1'b1, 24'h123456);
        clear_logs();

        // Blanking, no line pending: aux served back to back.
        blanking = 1'b1;
        aux_addr = 24'($urandom);
        aux_req  = 1'b1;
        chk_b2b  = 1'b1;
        k = 0;
        while (aux_dq.size() < 5 && k < 300) begin
            @(negedge vga_clk);
            k++;
        end
        chk_b2b = 1'b0;
        check_eq("t5_naux", 64'(aux_dq.size() >= 5), 64'd1);
        settle();
        blanking = 1'b0;
        check_aux("t5", 1'b0, aux_addr);
        clear_logs();

        // Random lines with a randomly toggling aux requester.
        for (int it = 0; it < 3; it++) begin
            ln = 10'($urandom_range(0, 1023));
            ab = 1'($urandom_range(0, 1));
            md = 1'($urandom_range(0, 1));
            words = md ? 1024 : 640;
            base = 24'(int'(ln) * words);
            aux_addr = 24'($urandom);
            start_line(ln, ab, md);
            wait_writes(words, 9000, 1'b1);
            settle();
            check_eq("t7_nwr", 64'(wq_sel.size()), 64'(words));
            check_line("t7", 0, words, ab, base);
            check_bursts("t7", 0, words / 64, base, words / 64);
            check_aux("t7", 1'b0, aux_addr);
            check_eq("t7_underrun", 64'(underrun), 64'd0);
            clear_logs();
        end

        // Missed deadline: new request mid-burst while line 10 is at pix 330.
        start_line(10'd10, 1'b0, 1'b0);
        wait_writes(330, 3000, 1'b0);
        start_line(10'd20, 1'b1, 1'b0);
        check_eq("t4_underrun", 64'(underrun), 64'd1);
        wait_writes(970, 6000, 1'b0);
        settle();
        check_eq("t4_nwr", 64'(wq_sel.size()), 64'd970);
        check_line("t4_old", 0, 330, 1'b0, 24'd6400);
        check_line("t4_new", 330, 640, 1'b1, 24'd12800);
        check_bursts("t4_old", 0, 6, 24'd6400, 16);
        check_bursts("t4_new", 6, 10, 24'd12800, 16);
        clear_logs();

        // Asynchronous reset in the middle of a burst.
        check_eq("t6_sticky", 64'(underrun), 64'd1);
        start_line(10'd100, 1'b0, 1'b0);
        wait_writes(100, 3000, 1'b0);
        #3;
        rst_n_w = 1'b0;
        #1;
        check_eq("t6_rst_a", 64'({mem_req, mem_addr, mem_len, buf_wr_en, buf_wr_sel,
                                  buf_wr_addr}), 64'd0);
        check_eq("t6_rst_b", 64'({buf_wr_data, aux_ack, aux_rvalid, aux_rdata, underrun}),
                 64'd0);
        repeat (3) @(negedge vga_clk);
        rst_n_w = 1'b1;
        clear_logs();
        repeat (2) @(negedge vga_clk);
        start_line(10'd7, 1'b1, 1'b1);
        wait_writes(1024, 8000, 1'b0);
        settle();
        check_eq("t6_nwr", 64'(wq_sel.size()), 64'd1024);
        check_line("t6", 0, 1024, 1'b1, 24'd7168);
        check_bursts("t6", 0, 16, 24'd7168, 16);
        check_eq("t6_underrun", 64'(underrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
